// File: rtl/board_state_store_if.sv
// Handshake, read-port and status bundle between game logic / renderer and the board store.
interface board_state_store_if #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
);
  logic             clr_req;
  logic             busy;
  logic             place_valid;
  logic             place_ready;
  logic [IDX_W-1:0] place_row;
  logic [IDX_W-1:0] place_col;
  logic [1:0]       place_color;
  logic             resp_valid;
  logic [1:0]       resp_code;
  logic [IDX_W-1:0] rd_row;
  logic [IDX_W-1:0] rd_col;
  logic [1:0]       rd_value;
  logic [CNT_W-1:0] stone_count;

  modport master (
    output clr_req, place_valid, place_row, place_col, place_color, rd_row, rd_col,
    input  busy, place_ready, resp_valid, resp_code, rd_value, stone_count
  );

  modport slave (
    input  clr_req, place_valid, place_row, place_col, place_color, rd_row, rd_col,
    output busy, place_ready, resp_valid, resp_code, rd_value, stone_count
  );
endinterface

// File: rtl/board_state_store.sv
// 15x15 Gomoku board of 2-bit cell codes: placement with legality response,
// 1-cycle renderer read port, and sequential one-cell-per-cycle board clear.
module board_state_store #(
  parameter int BOARD_SIZE = 15,
  parameter int IDX_W      = 4,
  parameter int CNT_W      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  board_state_store_if.slave bus
);

  localparam int CELLS = BOARD_SIZE * BOARD_SIZE;
  localparam int LIN_W = $clog2(CELLS);

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [1:0] RC_OK    = 2'b00;
  localparam logic [1:0] RC_OCC   = 2'b01;
  localparam logic [1:0] RC_RANGE = 2'b10;
  localparam logic [1:0] RC_COLOR = 2'b11;

  logic [1:0]       cells [CELLS];
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [LIN_W-1:0] clr_idx;
  logic [CNT_W-1:0] stone_count;
  logic             busy;
  logic             resp_valid;
  logic [1:0]       resp_code;
  logic [1:0]       rd_value_p1;
  logic             place_ready;
  logic             accept;
  logic [LIN_W-1:0] place_lin;
  logic [1:0]       place_code;
  logic [LIN_W-1:0] rd_lin;
  logic             rd_in;

  function automatic logic in_range(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    return (int'(r) < BOARD_SIZE) && (int'(c) < BOARD_SIZE);
  endfunction

  function automatic logic [LIN_W-1:0] lin_idx(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    return LIN_W'(int'(r) * BOARD_SIZE + int'(c));
  endfunction

  // Saturating increment: the count can never pass the number of cells.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (int'(v) >= CELLS) ? v : v + 1'b1;
  endfunction

  assign place_ready = (state == IDLE) & ~bus.clr_req;
  assign accept      = bus.place_valid & place_ready;
  assign rd_in       = in_range(bus.rd_row, bus.rd_col);
  assign rd_lin      = lin_idx(bus.rd_row, bus.rd_col);

  always_comb begin
    place_lin  = lin_idx(bus.place_row, bus.place_col);
    place_code = RC_OK;
    if (!in_range(bus.place_row, bus.place_col))
      place_code = RC_RANGE;
    else if (bus.place_color != 2'b01 && bus.place_color != 2'b10)
      place_code = RC_COLOR;
    else if (cells[place_lin] != 2'b00)
      place_code = RC_OCC;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_idx == LIN_W'(CELLS - 1)) state_nxt = IDLE;
      IDLE:    if (bus.clr_req) state_nxt = CLEAR;
               else if (accept) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Stage p1: control state, response and registered read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= CLEAR;
      clr_idx     <= '0;
      busy        <= 1'b1;
      resp_valid  <= 1'b0;
      resp_code   <= RC_OK;
      stone_count <= '0;
      rd_value_p1 <= 2'b00;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt == CLEAR);
      resp_valid <= (state_nxt == RESP);
      if (state == CLEAR)
        clr_idx <= clr_idx + 1'b1;
      else if (state == IDLE && bus.clr_req)
        clr_idx <= '0;
      if (state == IDLE && bus.clr_req) begin
        stone_count <= '0;
      end else if (accept) begin
        resp_code <= place_code;
        if (place_code == RC_OK)
          stone_count <= sat_inc(stone_count);
      end
      // Blank the renderer for the whole clear, including the edge that enters it.
      if (state == CLEAR || state_nxt == CLEAR || !rd_in)
        rd_value_p1 <= 2'b00;
      else
        rd_value_p1 <= cells[rd_lin];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR)
        cells[clr_idx] <= 2'b00;
      else if (accept && place_code == RC_OK)
        cells[place_lin] <= bus.place_color;
    end
  end

  assign bus.place_ready = place_ready;
  assign bus.busy        = busy;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_code   = resp_code;
  assign bus.rd_value    = rd_value_p1;
  assign bus.stone_count = stone_count;

endmodule

// File: tb/tb_board_state_store.sv
// Randomized self-checking bench for board_state_store against a board-level model.
module tb_board_state_store;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   mdl [15][15];
  int   mdl_cnt;

  board_state_store_if #(.IDX_W(4), .CNT_W(8)) bus ();

  board_state_store #(.BOARD_SIZE(15), .IDX_W(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_code(input int r, input int c, input int col);
    if (r >= 15 || c >= 15) return 2;
    if (col != 1 && col != 2) return 3;
    if (mdl[r][c] != 0) return 1;
    return 0;
  endfunction

  task automatic mdl_clear();
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        mdl[r][c] = 0;
    mdl_cnt = 0;
  endtask

  task automatic place_cmd(input int r, input int c, input int col,
                           output logic v, output logic [1:0] code);
    bus.place_row   = 4'(r);
    bus.place_col   = 4'(c);
    bus.place_color = 2'(col);
    bus.place_valid = 1'b1;
    step();
    v    = bus.resp_valid;
    code = bus.resp_code;
    bus.place_valid = 1'b0;
    step();
  endtask

  task automatic read_cell(input int r, input int c, output logic [1:0] v);
    bus.rd_row = 4'(r);
    bus.rd_col = 4'(c);
    step();
    v = bus.rd_value;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 1000) begin
      cnt++;
      bus.rd_row = (cnt % 2) ? 4'd0 : 4'd14;
      bus.rd_col = (cnt % 2) ? 4'd0 : 4'd14;
      step();
      if (bus.busy === 1'b1) begin
        total++;
        if (bus.rd_value !== 2'b00) begin
          bad++;
          $display("FAIL rd_during_clear: got %0d want 0", bus.rd_value);
        end
      end
    end
  endtask

  task automatic test_reset();
    int cnt;
    logic [1:0] v;
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if (bus.busy !== 1'b1 || bus.place_ready !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.resp_code !== 2'b00 || bus.rd_value !== 2'b00 || bus.stone_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%0b ready=%0b rv=%0b rc=%0d rd=%0d cnt=%0d want 1 0 0 0 0 0",
               bus.busy, bus.place_ready, bus.resp_valid, bus.resp_code, bus.rd_value, bus.stone_count);
    end
    rst_n = 1'b1;
    count_busy(cnt);
    total++;
    if (cnt != 225) begin
      bad++;
      $display("FAIL reset_busy_len: got %0d want 225", cnt);
    end
    total++;
    if (bus.place_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_clear: got %0b want 1", bus.place_ready);
    end
    read_cell(0, 0, v);
    total++;
    if (v !== 2'b00) begin bad++; $display("FAIL rd_0_0: got %0d want 0", v); end
    read_cell(14, 14, v);
    total++;
    if (v !== 2'b00) begin bad++; $display("FAIL rd_14_14: got %0d want 0", v); end
    mdl_clear();
  endtask

  task automatic test_basic();
    logic v;
    logic [1:0] code;
    logic [1:0] rv;
    place_cmd(7, 7, 1, v, code);
    total++;
    if (v !== 1'b1 || code !== 2'b00) begin
      bad++;
      $display("FAIL place_ok: vld=%0b code=%0d want 1 0", v, code);
    end
    mdl[7][7] = 1;
    mdl_cnt++;
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL resp_pulse_len: got %0b want 0", bus.resp_valid);
    end
    total++;
    if (bus.stone_count !== 8'(mdl_cnt)) begin
      bad++;
      $display("FAIL count_after_ok: got %0d want %0d", bus.stone_count, mdl_cnt);
    end
    read_cell(7, 7, rv);
    total++;
    if (rv !== 2'b01) begin bad++; $display("FAIL rd_7_7: got %0d want 1", rv); end
    place_cmd(7, 7, 2, v, code);
    total++;
    if (v !== 1'b1 || code !== 2'b01) begin
      bad++;
      $display("FAIL place_occupied: vld=%0b code=%0d want 1 1", v, code);
    end
    read_cell(7, 7, rv);
    total++;
    if (rv !== 2'b01 || bus.stone_count !== 8'(mdl_cnt)) begin
      bad++;
      $display("FAIL occupied_unchanged: cell=%0d cnt=%0d want 1 %0d", rv, bus.stone_count, mdl_cnt);
    end
  endtask

  task automatic test_errors();
    logic v;
    logic [1:0] code;
    logic [1:0] rv;
    int rs [4] = '{15, 3, 3, 4};
    int cs [4] = '{3, 3, 15, 4};
    int ks [4] = '{1, 3, 0, 0};
    for (int i = 0; i < 4; i++) begin
      place_cmd(rs[i], cs[i], ks[i], v, code);
      total++;
      if (v !== 1'b1 || int'(code) != exp_code(rs[i], cs[i], ks[i])) begin
        bad++;
        $display("FAIL err_code[%0d]: vld=%0b code=%0d want 1 %0d", i, v, code,
                 exp_code(rs[i], cs[i], ks[i]));
      end
    end
    read_cell(3, 3, rv);
    total++;
    if (rv !== 2'b00 || bus.stone_count !== 8'(mdl_cnt)) begin
      bad++;
      $display("FAIL err_no_change: cell=%0d cnt=%0d want 0 %0d", rv, bus.stone_count, mdl_cnt);
    end
    read_cell(15, 2, rv);
    total++;
    if (rv !== 2'b00) begin bad++; $display("FAIL rd_out_of_range: got %0d want 0", rv); end
  endtask

  task automatic test_random();
    logic v;
    logic [1:0] code;
    logic [1:0] rv;
    int r, c, k, e;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 15);
      c = $urandom_range(0, 15);
      k = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 2);
      e = exp_code(r, c, k);
      place_cmd(r, c, k, v, code);
      if (e == 0) begin
        mdl[r][c] = k;
        mdl_cnt++;
      end
      total++;
      if (v !== 1'b1 || int'(code) != e || bus.stone_count !== 8'(mdl_cnt)) begin
        bad++;
        $display("FAIL rand_place (%0d,%0d,%0d): vld=%0b code=%0d cnt=%0d want 1 %0d %0d",
                 r, c, k, v, code, bus.stone_count, e, mdl_cnt);
      end
    end
    for (int rr = 0; rr < 15; rr++)
      for (int cc = 0; cc < 15; cc++) begin
        read_cell(rr, cc, rv);
        total++;
        if (int'(rv) != mdl[rr][cc]) begin
          bad++;
          $display("FAIL rand_board (%0d,%0d): got %0d want %0d", rr, cc, rv, mdl[rr][cc]);
        end
      end
  endtask

  task automatic test_back_to_back();
    int q [$];
    int idx;
    int col;
    logic exp_v;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        if (mdl[r][c] == 0 && q.size() < 8) q.push_back(r * 15 + c);
    idx = 0;
    col = $urandom_range(1, 2);
    bus.place_row   = 4'(q[0] / 15);
    bus.place_col   = 4'(q[0] % 15);
    bus.place_color = 2'(col);
    bus.place_valid = 1'b1;
    for (int s = 1; s <= 2 * q.size(); s++) begin
      step();
      exp_v = (s % 2) == 1;
      total++;
      if (bus.resp_valid !== exp_v || bus.place_ready !== !exp_v) begin
        bad++;
        $display("FAIL b2b_cycle %0d: rv=%0b ready=%0b want %0b %0b", s, bus.resp_valid,
                 bus.place_ready, exp_v, !exp_v);
      end
      if (bus.resp_valid === 1'b1 && idx < q.size()) begin
        mdl[q[idx] / 15][q[idx] % 15] = col;
        mdl_cnt++;
        total++;
        if (bus.resp_code !== 2'b00 || bus.stone_count !== 8'(mdl_cnt)) begin
          bad++;
          $display("FAIL b2b_accept %0d: code=%0d cnt=%0d want 0 %0d", idx, bus.resp_code,
                   bus.stone_count, mdl_cnt);
        end
        idx++;
        if (idx < q.size()) begin
          col = $urandom_range(1, 2);
          bus.place_row   = 4'(q[idx] / 15);
          bus.place_col   = 4'(q[idx] % 15);
          bus.place_color = 2'(col);
        end else begin
          bus.place_valid = 1'b0;
        end
      end
    end
    bus.place_valid = 1'b0;
  endtask

  task automatic test_clear();
    int cnt;
    logic [1:0] rv;
    bus.place_row   = 4'd0;
    bus.place_col   = 4'd14;
    bus.place_color = 2'b10;
    bus.place_valid = 1'b1;
    bus.clr_req     = 1'b1;
    #1;
    total++;
    if (bus.place_ready !== 1'b0) begin
      bad++;
      $display("FAIL clr_blocks_ready: got %0b want 0", bus.place_ready);
    end
    step();
    total++;
    if (bus.busy !== 1'b1 || bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL clr_start: busy=%0b rv=%0b want 1 0", bus.busy, bus.resp_valid);
    end
    bus.clr_req     = 1'b0;
    bus.place_valid = 1'b0;
    count_busy(cnt);
    mdl_clear();
    total++;
    if (cnt != 225 || bus.stone_count !== 8'd0) begin
      bad++;
      $display("FAIL clr_len: busy=%0d cnt=%0d want 225 0", cnt, bus.stone_count);
    end
    for (int rr = 0; rr < 15; rr++)
      for (int cc = 0; cc < 15; cc++) begin
        read_cell(rr, cc, rv);
        total++;
        if (rv !== 2'b00) begin
          bad++;
          $display("FAIL clr_board (%0d,%0d): got %0d want 0", rr, cc, rv);
        end
      end
  endtask

  task automatic test_reset_mid();
    int cnt;
    logic [1:0] rv;
    // Command presented on the reset edge itself.
    bus.place_row = 4'd2; bus.place_col = 4'd2; bus.place_color = 2'b01;
    bus.place_valid = 1'b1;
    rst_n = 1'b0;
    step();
    bus.place_valid = 1'b0;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1 || bus.stone_count !== 8'd0) begin
      bad++;
      $display("FAIL rst_on_accept: rv=%0b busy=%0b cnt=%0d want 0 1 0", bus.resp_valid,
               bus.busy, bus.stone_count);
    end
    rst_n = 1'b1;
    count_busy(cnt);
    total++;
    if (cnt != 225) begin bad++; $display("FAIL rst_accept_len: got %0d want 225", cnt); end
    read_cell(2, 2, rv);
    total++;
    if (rv !== 2'b00) begin bad++; $display("FAIL rst_accept_cell: got %0d want 0", rv); end
    // Reset during RESP, then again at clear index 100.
    bus.place_row = 4'd5; bus.place_col = 4'd5; bus.place_color = 2'b01;
    bus.place_valid = 1'b1;
    step();
    bus.place_valid = 1'b0;
    total++;
    if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL mid_resp_enter: got %0b want 1", bus.resp_valid); end
    rst_n = 1'b0;
    step();
    total++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_resp: rv=%0b busy=%0b want 0 1", bus.resp_valid, bus.busy);
    end
    rst_n = 1'b1;
    repeat (100) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_busy(cnt);
    mdl_clear();
    total++;
    if (cnt != 225 || bus.stone_count !== 8'd0 || bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_clear: busy=%0d cnt=%0d rv=%0b want 225 0 0", cnt,
               bus.stone_count, bus.resp_valid);
    end
    read_cell(5, 5, rv);
    total++;
    if (rv !== 2'b00) begin bad++; $display("FAIL rst_resp_cell: got %0d want 0", rv); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.clr_req     = 1'b0;
    bus.place_valid = 1'b0;
    bus.place_row   = 4'd0;
    bus.place_col   = 4'd0;
    bus.place_color = 2'b00;
    bus.rd_row      = 4'd0;
    bus.rd_col      = 4'd0;
    mdl_clear();
    test_reset();
    test_basic();
    test_errors();
    test_random();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
